// File: rtl/bus_ctl.sv
// rtl/bus_ctl.sv - 65C02 memory/bus controller: internal RAM plus external req/ack bus
//
// Optional feature macro: POSTED_WRITE_EN (one-entry posted external write buffer).
//
// Ports:
//   clk        CPU clock
//   RST        synchronous active-high reset
//   AB/WE/DO   CPU address, write enable, write data
//   DI         read data to CPU (registered)
//   RDY        1 = CPU may advance, 0 = CPU holds AB/WE/DO
//   ext_addr   external address (stable while ext_req)
//   ext_wdata  external write data
//   ext_we     external write qualifier
//   ext_req    external request
//   ext_ack    external acknowledge (ignored while ext_req=0)
//   ext_rdata  external read data, valid with ext_ack
//   bus_err    sticky timeout flag, cleared only by RST

module bus_ctl #(
    parameter int RAM_AW  = 15,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AB,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_ABORT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_rdy, w_rdy_nxt;
    logic        r_req, w_req_nxt;
    logic        r_we, w_we_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic        r_err, w_err_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_di, w_di_nxt;
    logic        r_di_ram, w_di_ram_nxt;
    logic [7:0]  r_ram_q;
    logic [7:0]  r_mem [0:(1<<RAM_AW)-1];

    logic        w_ram_hit;
    logic        w_ram_rd;
    logic        w_ram_wr;
    logic        w_ext_iss;
    logic        w_post;

    assign w_ram_hit = ((AB >> RAM_AW) == 16'd0);
    assign w_ram_rd  = r_rdy && w_ram_hit && !WE;
    assign w_ram_wr  = r_rdy && w_ram_hit && WE;
    assign w_ext_iss = r_rdy && !w_ram_hit;

`ifdef POSTED_WRITE_EN
    assign w_post = WE;
`else
    assign w_post = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_rdy_nxt    = r_rdy;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        w_di_nxt     = r_di;
        w_di_ram_nxt = r_di_ram;

        // RAM reads select the RAM output register onto DI; they can overlap a posted drain.
        if (w_ram_rd) begin
            w_di_ram_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_ext_iss) begin
                    w_addr_nxt  = AB;
                    w_we_nxt    = WE;
                    w_wdata_nxt = DO;
                    w_req_nxt   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_rdy_nxt   = w_post;
                    w_state_nxt = S_EXT;
                end else begin
                    // Recovers from a stall raised on the cycle a drain finished.
                    w_rdy_nxt = 1'b1;
                end
            end
            S_EXT: begin
                if (ext_ack) begin
                    w_req_nxt = 1'b0;
                    if (!r_we) begin
                        w_di_nxt     = ext_rdata;
                        w_di_ram_nxt = 1'b0;
                    end
                    // An external access issued on this very edge waits one cycle and is re-issued.
                    w_rdy_nxt   = !w_ext_iss;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_req_nxt = 1'b0;
                    w_err_nxt = 1'b1;
                    if (!r_we) begin
                        w_di_nxt     = 8'hFF;
                        w_di_ram_nxt = 1'b0;
                    end
                    // A stalled CPU stays held through ABORT; a CPU running past a posted write keeps going.
                    w_rdy_nxt   = r_rdy && !w_ext_iss;
                    w_state_nxt = S_ABORT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (w_ext_iss) begin
                        w_rdy_nxt = 1'b0;
                    end
                end
            end
            S_ABORT: begin
                // ext_ack is deliberately not looked at here: a late ack is swallowed.
                w_rdy_nxt   = !w_ext_iss;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_rdy    <= 1'b1;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 16'd0;
            r_wdata  <= 8'd0;
            r_err    <= 1'b0;
            r_cnt    <= 8'd0;
            r_di     <= 8'd0;
            r_di_ram <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy    <= w_rdy_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
            r_di     <= w_di_nxt;
            r_di_ram <= w_di_ram_nxt;
        end
    end

    // Synchronous RAM; contents are not reset.
    always_ff @(posedge clk) begin
        if (!RST) begin
            if (w_ram_wr) begin
                r_mem[AB[RAM_AW-1:0]] <= DO;
            end
            if (w_ram_rd) begin
                r_ram_q <= r_mem[AB[RAM_AW-1:0]];
            end
        end
    end

    assign DI        = r_di_ram ? r_ram_q : r_di;
    assign RDY       = r_rdy;
    assign ext_addr  = r_addr;
    assign ext_wdata = r_wdata;
    assign ext_we    = r_we;
    assign ext_req   = r_req;
    assign bus_err   = r_err;

endmodule

// File: tb/tb_bus_ctl.sv
// tb/tb_bus_ctl.sv - self-checking bench for bus_ctl

module tb_bus_ctl;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic        tb_ack;
    logic [7:0]  tb_rdata;

    logic [7:0]  di_a, ewd_a;
    logic        rdy_a, ewe_a, ereq_a, err_a;
    logic [15:0] ea_a;

    logic [7:0]  di_b, ewd_b;
    logic        rdy_b, ewe_b, ereq_b, err_b;
    logic [15:0] ea_b;
    logic        dev_ack = 1'b0;
    logic [7:0]  dev_rdata = 8'd0;

    int n_pass = 0;
    int n_chk  = 0;
    int n;

    always #5 clk = ~clk;

    bus_ctl #(.RAM_AW(15), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO),
        .DI(di_a), .RDY(rdy_a), .ext_addr(ea_a), .ext_wdata(ewd_a), .ext_we(ewe_a),
        .ext_req(ereq_a), .ext_ack(tb_ack), .ext_rdata(tb_rdata), .bus_err(err_a)
    );

    bus_ctl #(.RAM_AW(15), .TIMEOUT(64)) u_dut_b (
        .clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO),
        .DI(di_b), .RDY(rdy_b), .ext_addr(ea_b), .ext_wdata(ewd_b), .ext_we(ewe_b),
        .ext_req(ereq_b), .ext_ack(dev_ack), .ext_rdata(dev_rdata), .bus_err(err_b)
    );

    // Slow device for instance B: acks after dev_lat cycles of ext_req, logs completions.
    logic        dev_en = 1'b0;
    int          dev_lat = 5;
    int          dev_cnt = 0;
    logic [7:0]  dev_mem [logic [15:0]];
    logic        lg_we [$];
    logic [15:0] lg_addr [$];
    logic [7:0]  lg_data [$];

    always @(negedge clk) begin
        if (!dev_en || !ereq_b) begin
            dev_ack = 1'b0;
            dev_cnt = 0;
        end else if (dev_cnt == dev_lat - 1) begin
            dev_ack = 1'b1;
            dev_cnt = 0;
            dev_rdata = dev_mem.exists(ea_b) ? dev_mem[ea_b] : 8'hEE;
            if (ewe_b) dev_mem[ea_b] = ewd_b;
            lg_we.push_back(ewe_b);
            lg_addr.push_back(ea_b);
            lg_data.push_back(ewd_b);
        end else begin
            dev_ack = 1'b0;
            dev_cnt++;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_rdy(input int max, output int cnt);
        cnt = 0;
        while (rdy_b !== 1'b1 && cnt < max) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] ab;
        logic        we;
        logic [7:0]  dout;
        logic        ack;
        logic [7:0]  rdata;
        logic        e_rdy;
        logic        e_req;
        logic        e_err;
        logic        c_di;
        logic [7:0]  e_di;
        logic        c_addr;
        logic [15:0] e_addr;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; AB = 16'h0200; WE = 1'b0; DO = 8'h00; tb_ack = 1'b0; tb_rdata = 8'h00;

        //            rst  ab        we    do     ack   rdata  rdy   req   err   cdi   di     cad   addr
        vec[0]  = '{1'b0, 16'h0200, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'h0000};
        vec[1]  = '{1'b0, 16'h0200, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        vec[2]  = '{1'b0, 16'hF000, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 16'h0000};
        vec[3]  = '{1'b0, 16'hF000, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF000};
        vec[4]  = '{1'b0, 16'hF000, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF000};
        vec[5]  = '{1'b0, 16'hF000, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF000};
        vec[6]  = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 16'h0000};
        vec[7]  = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h9000};
        vec[8]  = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        vec[9]  = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        vec[10] = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        vec[11] = '{1'b0, 16'h9000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 16'h0000};
        vec[12] = '{1'b0, 16'h0200, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 16'h0000};
        vec[13] = '{1'b0, 16'hA000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 16'h0000};
        vec[14] = '{1'b1, 16'hA000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'hA000};
        vec[15] = '{1'b0, 16'h0200, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'h0000};
        vec[16] = '{1'b0, 16'h0200, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 16'h0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",   16'(rdy_a),  16'h0001);
        chk("rst_di",    16'(di_a),   16'h0000);
        chk("rst_req",   16'(ereq_a), 16'h0000);
        chk("rst_we",    16'(ewe_a),  16'h0000);
        chk("rst_addr",  ea_a,        16'h0000);
        chk("rst_wdata", 16'(ewd_a),  16'h0000);
        chk("rst_err",   16'(err_a),  16'h0000);

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_rdy", i), 16'(rdy_a),  16'(vec[i].e_rdy));
            chk($sformatf("v%0d_req", i), 16'(ereq_a), 16'(vec[i].e_req));
            chk($sformatf("v%0d_err", i), 16'(err_a),  16'(vec[i].e_err));
            if (vec[i].c_di)   chk($sformatf("v%0d_di", i), 16'(di_a), 16'(vec[i].e_di));
            if (vec[i].c_addr) chk($sformatf("v%0d_addr", i), ea_a, vec[i].e_addr);
            RST = vec[i].rst; AB = vec[i].ab; WE = vec[i].we; DO = vec[i].dout;
            tb_ack = vec[i].ack; tb_rdata = vec[i].rdata;
            @(negedge clk);
        end

        // Write 0x8000, RAM read 0x0010, external read 0x8000; device acks after 5 cycles.
        RST = 1'b1; AB = 16'h0200; WE = 1'b0; tb_ack = 1'b0;
        @(negedge clk);
        RST = 1'b0; dev_lat = 5; dev_en = 1'b1;
        AB = 16'h0010; WE = 1'b1; DO = 8'h77;
        @(negedge clk);
        chk("seq_pre_rdy", 16'(rdy_b), 16'h0001);
        AB = 16'h8000; WE = 1'b1; DO = 8'h11;
        @(negedge clk);
        chk("seq_wr_req",  16'(ereq_b), 16'h0001);
        chk("seq_wr_addr", ea_b, 16'h8000);
`ifdef POSTED_WRITE_EN
        chk("pw_rdy_during_drain", 16'(rdy_b), 16'h0001);
        AB = 16'h0010; WE = 1'b0;
        @(negedge clk);
        chk("pw_ram_rdy", 16'(rdy_b), 16'h0001);
        chk("pw_ram_di",  16'(di_b),  16'h0077);
        chk("pw_ram_req", 16'(ereq_b), 16'h0001);
        AB = 16'h8000; WE = 1'b0;
        @(negedge clk);
        wait_rdy(20, n);
        chk("pw_rd_stall", 16'(n), 16'd3);
        chk("pw_req_gap",  16'(ereq_b), 16'h0000);
        chk("pw_wr_first", 16'(lg_we.size()), 16'd1);
        @(negedge clk);
        chk("pw_rd_rdy",  16'(rdy_b),  16'h0000);
        chk("pw_rd_req",  16'(ereq_b), 16'h0001);
        chk("pw_rd_we",   16'(ewe_b),  16'h0000);
        chk("pw_rd_addr", ea_b, 16'h8000);
        wait_rdy(20, n);
        chk("pw_rd_wait", 16'(n), 16'd5);
`else
        chk("np_wr_stall_rdy", 16'(rdy_b), 16'h0000);
        wait_rdy(20, n);
        chk("np_wr_stall", 16'(n), 16'd5);
        chk("np_wr_done",  16'(lg_we.size()), 16'd1);
        AB = 16'h0010; WE = 1'b0;
        @(negedge clk);
        chk("np_ram_rdy", 16'(rdy_b), 16'h0001);
        chk("np_ram_di",  16'(di_b),  16'h0077);
        AB = 16'h8000; WE = 1'b0;
        @(negedge clk);
        chk("np_rd_rdy", 16'(rdy_b),  16'h0000);
        chk("np_rd_req", 16'(ereq_b), 16'h0001);
        chk("np_rd_we",  16'(ewe_b),  16'h0000);
        wait_rdy(20, n);
        chk("np_rd_wait", 16'(n), 16'd5);
`endif
        chk("seq_rd_di",   16'(di_b), 16'h0011);
        chk("seq_log_len", 16'(lg_we.size()), 16'd2);
        if (lg_we.size() == 2) begin
            chk("seq_log0_we",   16'(lg_we[0]), 16'h0001);
            chk("seq_log0_addr", lg_addr[0],    16'h8000);
            chk("seq_log0_data", 16'(lg_data[0]), 16'h0011);
            chk("seq_log1_we",   16'(lg_we[1]), 16'h0000);
        end

        // Minimum latency: issue at t, ack at t+1, data at t+2 (AB still 0x8000 read).
        dev_lat = 1;
        @(negedge clk);
        chk("lat_rdy_lo", 16'(rdy_b),  16'h0000);
        chk("lat_req",    16'(ereq_b), 16'h0001);
        AB = 16'h0200;
        @(negedge clk);
        chk("lat_rdy_hi", 16'(rdy_b), 16'h0001);
        chk("lat_di",     16'(di_b),  16'h0011);
        chk("seq_no_err", 16'(err_b), 16'h0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
